// File: rtl/clk_div_bank.sv
// Bank of phase-aligned integer clock dividers with runtime reconfiguration.
// Latency: locked rises LOCK_CYCLES+2 edges after reset release or LOCK_CYCLES+1 edges after a write.
// Backpressure: cfg_ready is high only while LOCKED; a held cfg_valid waits for lock.
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam logic [1:0] S_RESET   = 2'd0;
    localparam logic [1:0] S_ALIGN   = 2'd1;
    localparam logic [1:0] S_LOCKING = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOCK_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [LC_W-1:0]  lock_cnt;
    logic             accept;
    logic [DIV_W-1:0] div_eff, phase_eff;

    logic [DIV_W-1:0] div_q   [NUM_CH];
    logic [DIV_W-1:0] phase_q [NUM_CH];
    logic [DIV_W-1:0] cnt_q   [NUM_CH];
    logic [DIV_W-1:0] div_nxt   [NUM_CH];
    logic [DIV_W-1:0] phase_nxt [NUM_CH];
    logic [DIV_W-1:0] cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] ce_nxt, outclk_nxt;

    assign accept = cfg_valid && cfg_ready;

    // Sanitise the incoming request: div 0 acts as 1, out-of-range phase collapses to 0.
    always_comb begin
        div_eff   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        phase_eff = (cfg_phase >= div_eff) ? '0 : cfg_phase;
    end

    // Next-state decode of the alignment FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:   state_nxt = S_ALIGN;
            S_ALIGN:   state_nxt = S_LOCKING;
            S_LOCKING: state_nxt = (lock_cnt == LC_LAST) ? S_LOCKED : S_LOCKING;
            S_LOCKED:  state_nxt = accept ? S_ALIGN : S_LOCKED;
            default:   state_nxt = S_RESET;
        endcase
    end

    // Per-channel next values; outputs are derived from the next counter so the
    // registered ce/outclk line up with the counter value of the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_nxt[i]   = div_q[i];
            phase_nxt[i] = phase_q[i];
            cnt_nxt[i]   = cnt_q[i];
            // A channel index beyond NUM_CH matches no channel, so the write is dropped.
            if (accept && (cfg_ch == CH_W'(i))) begin
                div_nxt[i]   = div_eff;
                phase_nxt[i] = phase_eff;
            end
            if (state == S_ALIGN) begin
                cnt_nxt[i] = phase_q[i];
            end else if (state == S_LOCKED) begin
                cnt_nxt[i] = (cnt_q[i] == div_q[i] - 1'b1) ? '0 : cnt_q[i] + 1'b1;
            end
            ce_nxt[i]     = (state_nxt == S_LOCKED) && (cnt_nxt[i] == div_nxt[i] - 1'b1);
            outclk_nxt[i] = (state_nxt == S_LOCKED) &&
                            ({1'b0, cnt_nxt[i]} < (({1'b0, div_nxt[i]} + 1'b1) >> 1));
        end
    end

    // Control state, settle counter and status outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_RESET;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            ce        <= '0;
            outclk    <= '0;
        end else begin
            state     <= state_nxt;
            lock_cnt  <= (state == S_LOCKING) ? lock_cnt + 1'b1 : '0;
            locked    <= (state_nxt == S_LOCKED);
            cfg_ready <= (state_nxt == S_LOCKED);
            ce        <= ce_nxt;
            outclk    <= outclk_nxt;
        end
    end

    // Per-channel configuration and phase counters.
    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end else begin
                div_q[i]   <= div_nxt[i];
                phase_q[i] <= phase_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised bench for clk_div_bank against a time-based reference model.
// Expected outputs come from (phase + cycles since lock) mod div.
// Inputs change on the falling edge, outputs are compared on the falling edge.
module tb_clk_div_bank;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int LC     = 16;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] ce;
    logic              locked;

    always #5 refclk = ~refclk;

    clk_div_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LC), .DEFAULT_DIV(2)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .outclk(outclk), .ce(ce), .locked(locked)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: in reset, or aligned at edge m_align and locked from m_align+LC+1.
    bit m_rst   = 1'b1;
    int m_align = 0;
    int m_div [NUM_CH];
    int m_ph  [NUM_CH];

    function automatic bit m_locked(input int n);
        return !m_rst && (n >= m_align + LC + 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Check the current cycle, then apply inputs for the next edge.
    task automatic tick(input bit r, input bit v, input int ch, input int dv, input int ph);
        int eo, ec, k, c, d;
        @(negedge refclk);
        eo = 0;
        ec = 0;
        if (m_locked(cyc)) begin
            k = cyc - (m_align + LC + 1);
            for (int i = 0; i < NUM_CH; i++) begin
                c = (m_ph[i] + k) % m_div[i];
                if (c < (m_div[i] + 1) / 2) eo |= (1 << i);
                if (c == m_div[i] - 1)      ec |= (1 << i);
            end
        end
        chk("locked",    int'(locked),    int'(m_locked(cyc)));
        chk("cfg_ready", int'(cfg_ready), int'(m_locked(cyc)));
        chk("outclk",    int'(outclk),    eo);
        chk("ce",        int'(ce),        ec);

        if (r) begin
            m_rst = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 2;
                m_ph[i]  = 0;
            end
        end else if (m_rst) begin
            m_rst   = 1'b0;
            m_align = cyc + 1;
        end else if (v && m_locked(cyc)) begin
            if (ch < NUM_CH) begin
                d = (dv == 0) ? 1 : dv;
                m_div[ch] = d;
                m_ph[ch]  = (ph >= d) ? 0 : ph;
            end
            m_align = cyc + 1;
        end

        rst       = r;
        cfg_valid = v;
        cfg_ch    = 2'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        @(posedge refclk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = 2;
            m_ph[i]  = 0;
        end
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        @(posedge refclk);
        cyc = 1;

        // Reset state and release with default dividers.
        tick(1'b1, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 0, 0, 0);
        idle(26);

        // ch1 div=5 phase=2.
        tick(1'b0, 1'b1, 1, 5, 2);
        idle(30);

        // div=0 behaves as div=1.
        tick(1'b0, 1'b1, 2, 0, 0);
        idle(25);

        // Phase beyond div is stored as 0.
        tick(1'b0, 1'b1, 3, 4, 7);
        idle(25);

        // cfg_valid held from reset: waits for lock, accepted on first locked edge.
        tick(1'b1, 1'b1, 0, 3, 1);
        for (int i = 0; i < 22; i++) tick(1'b0, 1'b1, 0, 3, 1);
        idle(25);

        // Reset during LOCKING with a pending request.
        tick(1'b0, 1'b1, 1, 7, 3);
        idle(5);
        tick(1'b1, 1'b1, 2, 6, 1);
        tick(1'b1, 1'b1, 2, 6, 1);
        idle(25);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 199) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, NUM_CH - 1)),
                 int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 11)));
        end
        idle(25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of divided-clock channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16, giving the divider and phase field width.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, giving the settle interval in cycles (>=1).
REQ-004 SHALL have parameter DEFAULT_DIV, default 2, giving the reset divide value of every channel.
REQ-005 SHALL derive CH_W as max(1, clog2(NUM_CH)).
REQ-006 SHALL have a single clock and a synchronous, active-high reset; all state changes on the rising edge of refclk.
REQ-007 SHALL have port refclk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port cfg_valid, input, 1 bit: a reconfiguration request is present.
REQ-010 SHALL have port cfg_ready, output, 1 bit: the block can accept a request.
REQ-011 SHALL have port cfg_ch, input, CH_W bits: the target channel.
REQ-012 SHALL have port cfg_div, input, DIV_W bits: the new divide ratio.
REQ-013 SHALL have port cfg_phase, input, DIV_W bits: the new start phase in refclk cycles.
REQ-014 SHALL have port outclk, output, NUM_CH bits: registered divided clocks.
REQ-015 SHALL have port ce, output, NUM_CH bits: registered one-cycle clock-enable pulses.
REQ-016 SHALL have port locked, output, 1 bit: outputs are valid and stable.

Function
REQ-017 SHALL hold, per channel, div[i], phase[i] and counter cnt[i], each DIV_W bits.
REQ-018 SHALL implement the FSM states RESET, ALIGN, LOCKING and LOCKED.
REQ-019 SHALL make the transitions: RESET->ALIGN on the first edge with rst low; ALIGN->LOCKING after exactly 1 cycle; LOCKING->LOCKED after exactly LOCK_CYCLES cycles; LOCKED->ALIGN on an accepted request.
REQ-020 SHALL load every cnt[i] with phase[i] in ALIGN and hold cnt[i] at that value throughout LOCKING.
REQ-021 SHALL, in LOCKED, advance each counter every cycle as cnt[i] = (cnt[i] == div[i]-1) ? 0 : cnt[i]+1.
REQ-022 SHALL make cnt[i] equal phase[i] in the first LOCKED cycle, so inter-channel phase relations are deterministic.
REQ-023 SHALL drive locked=1 exactly while the state is LOCKED, as a registered output.
REQ-024 SHALL make ce[i] and outclk[i] registers whose value in a cycle reflects that same cycle's cnt[i]: ce[i]=1 iff LOCKED and cnt[i]==div[i]-1; outclk[i]=1 iff LOCKED and cnt[i] < ceil(div[i]/2).
REQ-025 SHALL hold ce and outclk at 0 in every non-LOCKED state, giving a glitch-free stop and start.
REQ-026 SHALL drive cfg_ready=1 exactly while LOCKED; a request is accepted on an edge where cfg_valid and cfg_ready are both 1.
REQ-027 SHALL, on the accepting edge, update only div[cfg_ch] and phase[cfg_ch], enter ALIGN, and have locked, ce and outclk read 0 from the next cycle.
REQ-028 SHALL realign all channels on every accepted request, not only the reconfigured one.
REQ-029 SHALL store cfg_div=0 as div=1; with div=1, ce and outclk are constantly 1 while LOCKED.
REQ-030 SHALL store cfg_phase as 0 when cfg_phase >= the stored (effective) div.
REQ-031 SHALL ignore a write when cfg_ch >= NUM_CH, while still performing the handshake and realignment.
REQ-032 SHALL leave a cfg_valid asserted outside LOCKED unaccepted; it is accepted on the first LOCKED edge if still asserted.

Reset
REQ-033 SHALL, on any edge with rst=1, set state=RESET, locked=0, cfg_ready=0, ce=0, outclk=0, all cnt=0, all div=DEFAULT_DIV and all phase=0.
REQ-034 SHALL give rst priority over a simultaneous cfg handshake and over any in-progress ALIGN or LOCKING; pending configuration is discarded.
REQ-035 SHALL, after rst deasserts, raise locked on edge LOCK_CYCLES+2 counted from the first edge with rst low.

Verification
REQ-036 Reset release with defaults -> locked=1 after edge 18; every channel gives outclk 1,0,1,0 and ce 0,1,0,1 from the first LOCKED cycle.
REQ-037 In LOCKED, write ch1 div=5 phase=2 -> locked=0 for 17 cycles; then ch1 outclk 1,0,0,1,1 repeating, ce=1 in the 3rd LOCKED cycle and every 5 after; ch0/2/3 unchanged at div 2.
REQ-038 Write div=0 -> channel runs as div=1: ce and outclk constantly 1 while locked.
REQ-039 Write div=4 phase=7 -> phase stored as 0: outclk 1,1,0,0 and ce on the 4th cycle.
REQ-040 Hold cfg_valid high from reset -> cfg_ready=0 until locked; accepted on the first LOCKED edge; locked drops on the next cycle.
REQ-041 Assert rst during LOCKING with cfg_valid=1 -> all outputs 0 on the next edge; after release, the default div=2 behaviour of REQ-036 resumes.
